// File: rtl/interrupt_sequencer_pkg.sv
// interrupt_sequencer_pkg: shared states and opcodes for the interrupt entry sequencer
package interrupt_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_HI,
    S_PUSH_LO,
    S_VECTOR
  } state_e;
  localparam logic [15:0] OP_NOP = 16'h0000;
  localparam logic [15:0] OP_INT_PUSH = {5'b11110, 11'b0};
  localparam logic [31:0] DEFAULT_VECTOR_ADDR = 32'h0000_0000;
endpackage

// File: rtl/interrupt_sequencer_edge_detect.sv
// int_edge_detect: rising-edge detector armed only after the level has been seen low out of reset
module int_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);
  logic low_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) low_q <= 1'b0;
    else low_q <= ~level_i;
  assign rise_o = level_i & low_q;
endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: drains the pipeline, pushes the resume PC and vectors fetch on interrupt entry
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] VECTOR_ADDR = DEFAULT_VECTOR_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  input  logic [31:0] pc,
  input  logic        branch_pending,
  input  logic [31:0] branch_addr,
  input  logic [3:0]  ccr,
  input  logic        rti_commit,
  output logic        stall_fetch,
  output logic        inject_valid,
  output logic [15:0] inject_instr,
  output logic [15:0] push_data,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic [3:0]  saved_ccr,
  output logic        restore_ccr,
  output logic        busy
);
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  state_e state_q, state_d;
  logic pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] resume_q, resume_d;
  logic [3:0] ccr_q, ccr_d;
  logic restore_q;
  logic rise;
  int_edge_detect u_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (interrupt),
    .rise_o  (rise)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      resume_q  <= '0;
      ccr_q     <= '0;
      restore_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      resume_q  <= resume_d;
      ccr_q     <= ccr_d;
      restore_q <= rti_commit && state_q == S_IDLE;
    end
  // An RTI in the same cycle defers entry so the flag restore lands first.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | rise;
    cnt_d        = cnt_q;
    resume_d     = resume_q;
    ccr_d        = ccr_q;
    stall_fetch  = 1'b0;
    inject_valid = 1'b0;
    inject_instr = OP_NOP;
    push_data    = '0;
    pc_load      = 1'b0;
    pc_load_addr = '0;
    case (state_q)
      S_IDLE:
        if ((pending_q | rise) && !branch_pending && !rti_commit) begin
          state_d   = S_DRAIN;
          pending_d = 1'b0;
          cnt_d     = CW'(DRAIN_CYCLES - 1);
          resume_d  = pc;
          ccr_d     = ccr;
        end
      S_DRAIN: begin
        stall_fetch  = 1'b1;
        inject_valid = 1'b1;
        cnt_d        = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        resume_d     = branch_pending ? branch_addr : resume_q;
        state_d      = cnt_q == '0 ? S_PUSH_HI : S_DRAIN;
      end
      S_PUSH_HI: begin
        stall_fetch  = 1'b1;
        inject_valid = 1'b1;
        inject_instr = OP_INT_PUSH;
        push_data    = resume_q[31:16];
        state_d      = S_PUSH_LO;
      end
      S_PUSH_LO: begin
        stall_fetch  = 1'b1;
        inject_valid = 1'b1;
        inject_instr = OP_INT_PUSH;
        push_data    = resume_q[15:0];
        state_d      = S_VECTOR;
      end
      S_VECTOR: begin
        pc_load      = 1'b1;
        pc_load_addr = VECTOR_ADDR;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign saved_ccr   = ccr_q;
  assign restore_ccr = restore_q;
  assign busy        = state_q != S_IDLE;
endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: number of NOP-injection cycles used to retire in-flight instructions before the pushes.
REQ-002 Parameter VECTOR_ADDR, default 32'h0000_0000: fetch address loaded on interrupt entry.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 interrupt  in  1  external request; a rising edge (low-to-high, sampled on clk) raises a request.
REQ-006 pc  in  32  fetch PC of the next unexecuted instruction (resume address).
REQ-007 branch_pending  in  1  taken branch resolving in execute this cycle (flush in progress).
REQ-008 branch_addr  in  32  target of that branch; valid when branch_pending=1.
REQ-009 ccr  in  4  current status flags.
REQ-010 rti_commit  in  1  RTI decoded this cycle (single-cycle pulse).
REQ-011 stall_fetch  out  1  hold PC and the IF/ID register.
REQ-012 inject_valid  out  1  decode takes inject_instr instead of IF/ID instruction.
REQ-013 inject_instr  out  16  injected instruction word.
REQ-014 push_data  out  16  data word accompanying an injected push.
REQ-015 pc_load  out  1  one-cycle pulse: fetch loads pc_load_addr.
REQ-016 pc_load_addr  out  32  address for pc_load.
REQ-017 saved_ccr  out  4  flags captured at interrupt entry.
REQ-018 restore_ccr  out  1  one-cycle pulse: status register loads saved_ccr.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 States: IDLE, DRAIN, PUSH_HI, PUSH_LO, VECTOR, encoded in a 3-bit register.
REQ-021 An interrupt rising edge sets pending; pending holds until IDLE->DRAIN, and a further edge while pending=1 is dropped.
REQ-022 IDLE->DRAIN when pending=1 and branch_pending=0; on that edge the block captures resume_pc<=pc, saved_ccr<=ccr, clears pending and loads drain counter with DRAIN_CYCLES-1.
REQ-023 IDLE with pending=1 and branch_pending=1: stay in IDLE; retry next cycle.
REQ-024 DRAIN: stall_fetch=1, inject_valid=1, inject_instr=NOP; counter decrements each cycle; DRAIN->PUSH_HI when counter=0 (exactly DRAIN_CYCLES cycles in DRAIN).
REQ-025 DRAIN with branch_pending=1: resume_pc<=branch_addr that cycle; the counter is unaffected.
REQ-026 PUSH_HI (1 cycle): stall_fetch=1, inject_valid=1, inject_instr=INT_PUSH, push_data=resume_pc[31:16]; -> PUSH_LO.
REQ-027 PUSH_LO (1 cycle): same with push_data=resume_pc[15:0]; -> VECTOR.
REQ-028 VECTOR (1 cycle): stall_fetch=0, inject_valid=0, pc_load=1, pc_load_addr=VECTOR_ADDR; -> IDLE.
REQ-029 Entry latency: edge sampled at cycle N -> DRAIN at N+1 -> pc_load at N+DRAIN_CYCLES+3 (branch_pending low).
REQ-030 rti_commit in IDLE: restore_ccr=1 next cycle; rti_commit outside IDLE is ignored.
REQ-031 rti_commit and interrupt edge in the same IDLE cycle: restore_ccr pulses first and the entry begins the following cycle (restore before entry).
REQ-032 Outputs not driven by the current state are 0; push_data=0 outside PUSH states; pc_load_addr=0 outside VECTOR.

Reset
REQ-033 reset asserted: state=IDLE, pending=0, counter=0, resume_pc=0, saved_ccr=0, edge-detect register=0; all outputs 0 immediately (asynchronous).
REQ-034 reset mid-sequence aborts it; no pc_load or restore_ccr pulse follows deassertion.
REQ-035 An interrupt held high through reset deassertion does not count as an edge.

Structure
REQ-036 Shared package holds the state enum, OP_NOP=16'h0000, INT_PUSH opcode constant (5'b11110 in [15:11], rest 0), and the default VECTOR_ADDR.
REQ-037 One sub-module: int_edge_detect (registered rising-edge detector with reset).

Verification
REQ-038 Reset, single interrupt pulse, pc=32'h0001_2345, ccr=4'b1010 -> 3 NOP cycles, pushes 16'h0001 then 16'h2345, pc_load to 32'h0 at N+6, saved_ccr=4'b1010.
REQ-039 Interrupt with branch_pending=1 for 2 cycles -> DRAIN entered 2 cycles late; then branch_pending in DRAIN with branch_addr=32'h0000_0040 -> pushes 16'h0000, 16'h0040.
REQ-040 Two interrupt edges during a sequence -> exactly one further entry follows, starting the cycle after VECTOR.
REQ-041 rti_commit and interrupt edge in the same cycle -> restore_ccr at N+1, busy rises at N+2.
REQ-042 reset asserted in PUSH_LO -> outputs 0 at once, state IDLE, no pc_load after release.
REQ-043 interrupt held high across reset release -> no sequence starts.
